vscale_dmem_responder: RTL

Responder end of the core's data-memory interface: accepts `dmem_en`/`dmem_wen`/`dmem_size` requests issued by the control unit in DX, holds the core in WB with `dmem_wait` for a programmable number of wait states, then returns read data or commits write data. It also flags misaligned, out-of-range and illegal-size accesses on `dmem_badmem_e`. It sits between the vscale pipeline and a word-organised scratchpad used for simulation and small FPGA builds.

---
 rtl/vscale_dmem_responder_pkg.sv | 15 +
 rtl/vscale_dmem_responder_if.sv | 24 ++
 rtl/vscale_dmem_check.sv | 41 ++++
 rtl/vscale_dmem_responder.sv | 93 +++++++++
 4 files changed

// File: rtl/vscale_dmem_responder_pkg.sv
// Shared encodings for the vscale data-memory responder:
// dmem_size lane-width codes and responder FSM state encodings.
package vscale_dmem_responder_pkg;

    localparam logic [1:0] DMEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] DMEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] DMEM_SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/vscale_dmem_responder_if.sv
// Core <-> responder data-memory bus.
// master: core drives request/store data; slave: responder returns rdata/wait/badmem.
interface vscale_dmem_responder_if;

    logic        dmem_en;
    logic        dmem_wen;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata_delayed;
    logic [31:0] dmem_rdata;
    logic        dmem_wait;
    logic        dmem_badmem_e;

    modport master (
        output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
        input  dmem_rdata, dmem_wait, dmem_badmem_e
    );

    modport slave (
        input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
        output dmem_rdata, dmem_wait, dmem_badmem_e
    );

endinterface

// File: rtl/vscale_dmem_check.sv
// Combinational access check: flags misaligned/out-of-range/illegal-size
// requests (bad) and produces the store byte-lane mask. Ports: addr, size in; bad, mask out.
module vscale_dmem_check
    import vscale_dmem_responder_pkg::*;
#(
    parameter int WORDS = 1024
) (
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    output logic        bad,
    output logic [3:0]  mask
);

    localparam logic [29:0] WORDS_L = 30'(WORDS);

    logic misaligned;
    logic illegal;
    logic out_of_range;

    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        mask       = 4'b0000;
        unique case (size)
            DMEM_SIZE_BYTE: mask = 4'b0001 << addr[1:0];
            DMEM_SIZE_HALF: begin
                misaligned = addr[0];
                mask       = 4'b0011 << addr[1:0];
            end
            DMEM_SIZE_WORD: begin
                misaligned = |addr[1:0];
                mask       = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign out_of_range = addr[31:2] >= WORDS_L;
    assign bad          = misaligned | illegal | out_of_range;

endmodule

// File: rtl/vscale_dmem_responder.sv
// Data-memory responder: accepts DX requests, inserts WAIT_STATES wait cycles,
// then completes (read word / byte-masked store / error). Ports: clk, reset, bus (slave).
module vscale_dmem_responder
    import vscale_dmem_responder_pkg::*;
#(
    parameter int WORDS       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    vscale_dmem_responder_if.slave  bus
);

    localparam int IW = $clog2(WORDS);
    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [31:0]   mem [WORDS];

    dmem_state_e   state;
    logic [3:0]    cnt;
    logic [IW-1:0] a_idx;
    logic [3:0]    a_mask;
    logic          a_wen;
    logic          a_bad;

    logic          chk_bad;
    logic [3:0]    chk_mask;
    logic          accept;
    logic          unused_size;

    assign unused_size = bus.dmem_size[2];

    vscale_dmem_check #(.WORDS(WORDS)) u_check (
        .addr (bus.dmem_addr),
        .size (bus.dmem_size[1:0]),
        .bad  (chk_bad),
        .mask (chk_mask)
    );

    // New requests are taken in IDLE and DONE (back-to-back), never in WAIT.
    assign accept = bus.dmem_en && (state != DMEM_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= DMEM_IDLE;
            cnt    <= '0;
            a_idx  <= '0;
            a_mask <= '0;
            a_wen  <= 1'b0;
            a_bad  <= 1'b0;
        end else begin
            unique case (state)
                DMEM_WAIT: begin
                    if (cnt == 4'd0) state <= DMEM_DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                default: begin
                    if (accept) begin
                        a_idx  <= bus.dmem_addr[IW+1:2];
                        a_mask <= chk_mask;
                        a_wen  <= bus.dmem_wen;
                        a_bad  <= chk_bad;
                        if (chk_bad || WAIT_STATES == 0) begin
                            state <= DMEM_DONE;
                        end else begin
                            state <= DMEM_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end else begin
                        state <= DMEM_IDLE;
                    end
                end
            endcase
        end
    end

    // Store commits on the edge closing DONE; reset on that edge aborts it.
    always_ff @(posedge clk) begin
        if (!reset && state == DMEM_DONE && a_wen && !a_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (a_mask[i]) begin
                    mem[a_idx][8*i +: 8] <= bus.dmem_wdata_delayed[8*i +: 8];
                end
            end
        end
    end

    assign bus.dmem_wait     = (state == DMEM_WAIT);
    assign bus.dmem_badmem_e = (state == DMEM_DONE) && a_bad;
    assign bus.dmem_rdata    = (state == DMEM_DONE && !a_bad) ? mem[a_idx] : 32'h0;

endmodule
